// File: rtl/l1_dcache_dm_pkg.sv
// Shared types and geometry constants for the direct-mapped L1 cache.
package cache_types;

    localparam int LINE_BITS    = 256;
    localparam int OFFSET_BITS  = 5;
    localparam int WORD_SEL     = 3;
    localparam int DEF_NUM_SETS = 16;
    localparam int TAG_BITS     = 32 - OFFSET_BITS - $clog2(DEF_NUM_SETS);

    typedef enum logic [1:0] {
        IDLE_CMP  = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_state_t;

    typedef logic [LINE_BITS-1:0] line_t;
    typedef logic [TAG_BITS-1:0]  tag_t;

endpackage

// File: rtl/l1_cache_array.sv
// Flop-based valid/dirty/tag/data storage with combinational read by index.
module l1_cache_array
    import cache_types::*;
#(
    parameter int NUM_SETS = 16,
    parameter int IDX_W    = $clog2(NUM_SETS),
    parameter int TAG_W    = 32 - OFFSET_BITS - IDX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     i_idx,
    input  logic                 i_word_we,
    input  logic [WORD_SEL-1:0]  i_word,
    input  logic [31:0]          i_wdata,
    input  logic [3:0]           i_be,
    input  logic                 i_load,
    input  logic [TAG_W-1:0]     i_load_tag,
    input  logic [LINE_BITS-1:0] i_load_data,
    input  logic                 i_dirty_clr,
    output logic                 o_valid,
    output logic                 o_dirty,
    output logic [TAG_W-1:0]     o_tag,
    output logic [LINE_BITS-1:0] o_line
);

    logic [NUM_SETS-1:0]  r_valid;
    logic [NUM_SETS-1:0]  r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_SETS];
    logic [LINE_BITS-1:0] r_data [NUM_SETS];

    // Status bits: a fill installs a clean line, writeback cleans it, a write hit dirties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_load) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= 1'b0;
        end else if (i_dirty_clr) begin
            r_dirty[i_idx] <= 1'b0;
        end else if (i_word_we) begin
            r_dirty[i_idx] <= 1'b1;
        end
    end

    // Tag and data carry no reset; valid qualifies them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (i_load) begin
                r_tag[i_idx]  <= i_load_tag;
                r_data[i_idx] <= i_load_data;
            end else if (i_word_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_be[b]) begin
                        r_data[i_idx][int'(i_word)*32 + b*8 +: 8] <= i_wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_line  = r_data[i_idx];

endmodule

// File: rtl/l1_dcache_dm.sv
// Direct-mapped write-back/write-allocate L1 cache: hits answer in the request cycle,
// misses run an optional victim writeback followed by a line fill.
module l1_dcache_dm
    import cache_types::*;
#(
    parameter int NUM_SETS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    input  logic [3:0]   mem_byte_enable,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 32 - OFFSET_BITS - IDX_W;

    cache_state_t         r_state;
    cache_state_t         w_next_state;
    logic [31:0]          r_miss_addr;
    logic [31:0]          w_cur_addr;
    logic [IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic [WORD_SEL-1:0]  w_word;
    logic                 w_req;
    logic                 w_hit;
    logic                 w_valid;
    logic                 w_dirty;
    logic [TAG_W-1:0]     w_tag_rd;
    logic [LINE_BITS-1:0] w_line;
    logic                 w_word_we;
    logic                 w_load;
    logic                 w_dirty_clr;

    // Once a miss is taken the latched address drives the arrays, so the burst is
    // unaffected if the CPU drops or changes its request.
    assign w_cur_addr = (r_state == IDLE_CMP) ? mem_address : r_miss_addr;
    assign w_idx      = w_cur_addr[OFFSET_BITS +: IDX_W];
    assign w_tag      = w_cur_addr[31 -: TAG_W];
    assign w_word     = mem_address[4:2];
    assign w_req      = mem_read | mem_write;
    assign w_hit      = w_valid && (w_tag_rd == w_tag);

    l1_cache_array #(.NUM_SETS(NUM_SETS)) u_array (
        .clk         (clk),
        .rst         (rst),
        .i_idx       (w_idx),
        .i_word_we   (w_word_we),
        .i_word      (w_word),
        .i_wdata     (mem_wdata),
        .i_be        (mem_byte_enable),
        .i_load      (w_load),
        .i_load_tag  (w_tag),
        .i_load_data (pmem_rdata),
        .i_dirty_clr (w_dirty_clr),
        .o_valid     (w_valid),
        .o_dirty     (w_dirty),
        .o_tag       (w_tag_rd),
        .o_line      (w_line)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE_CMP;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Miss address capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_miss_addr <= 32'd0;
        end else if ((r_state == IDLE_CMP) && w_req && !w_hit) begin
            r_miss_addr <= mem_address;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE_CMP: begin
                if (w_req && !w_hit) begin
                    w_next_state = (w_valid && w_dirty) ? WRITEBACK : ALLOCATE;
                end else begin
                    w_next_state = IDLE_CMP;
                end
            end
            WRITEBACK: begin
                if (pmem_resp) begin
                    w_next_state = ALLOCATE;
                end else begin
                    w_next_state = WRITEBACK;
                end
            end
            ALLOCATE: begin
                if (pmem_resp) begin
                    w_next_state = IDLE_CMP;
                end else begin
                    w_next_state = ALLOCATE;
                end
            end
            default: w_next_state = IDLE_CMP;
        endcase
    end

    // Output and array-control decode.
    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata    = 32'd0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 32'd0;
        pmem_wdata   = '0;
        w_word_we    = 1'b0;
        w_load       = 1'b0;
        w_dirty_clr  = 1'b0;
        if (rst) begin
            mem_resp = 1'b0;
        end else begin
            case (r_state)
                IDLE_CMP: begin
                    if (w_req && w_hit) begin
                        mem_resp  = 1'b1;
                        mem_rdata = w_line[{w_word, 5'b00000} +: 32];
                        w_word_we = mem_write;
                    end else begin
                        mem_resp = 1'b0;
                    end
                end
                WRITEBACK: begin
                    pmem_write   = 1'b1;
                    pmem_address = {w_tag_rd, w_idx, 5'b00000};
                    pmem_wdata   = w_line;
                    w_dirty_clr  = pmem_resp;
                end
                ALLOCATE: begin
                    pmem_read    = 1'b1;
                    pmem_address = {w_tag, w_idx, 5'b00000};
                    w_load       = pmem_resp;
                end
                default: begin
                    mem_resp = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_dcache_dm.sv
// Directed scoreboard bench for l1_dcache_dm with a latency-programmable memory responder.
module tb_l1_dcache_dm;

    typedef struct {
        logic        chk;
        logic [31:0] data;
    } sb_t;

    logic         clk;
    logic         rst;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int checks;
    int errors;
    sb_t sb[$];
    logic [255:0] mem_model [logic [31:0]];
    int lat;
    int wb_count;
    logic [31:0] last_wb;
    logic [31:0] last_fill;

    l1_dcache_dm #(.NUM_SETS(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    // Monitor: pop the oldest expectation each time the cache completes a request.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (!rst && mem_resp) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: got resp with empty scoreboard, expected none");
                end else begin
                    e = sb.pop_front();
                    if (e.chk) chk("rdata", mem_rdata, e.data);
                end
                chk("pmem_idle_on_resp", {30'd0, pmem_read, pmem_write}, 32'd0);
            end
        end
    end

    // Memory responder: answers after lat cycles and checks the request stays stable.
    initial begin
        int cnt;
        logic [31:0]  cap_a;
        logic [255:0] cap_w;
        cnt = 0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            if (pmem_read && pmem_write) begin
                checks++;
                errors++;
                $display("FAIL pmem_both: got read=1 write=1, expected at most one");
            end
            if (pmem_read || pmem_write) begin
                cnt++;
                if (cnt == 1) begin
                    cap_a = pmem_address;
                    cap_w = pmem_wdata;
                end else begin
                    chk("pmem_addr_stable", pmem_address, cap_a);
                    if (pmem_write) begin
                        checks++;
                        if (pmem_wdata !== cap_w) begin
                            errors++;
                            $display("FAIL pmem_wdata_stable: got %h expected %h", pmem_wdata, cap_w);
                        end
                    end
                end
                if (cnt >= lat) begin
                    if (pmem_write) begin
                        mem_model[pmem_address] = pmem_wdata;
                        last_wb = pmem_address;
                        wb_count++;
                    end else begin
                        pmem_rdata = mem_model.exists(pmem_address) ? mem_model[pmem_address] : '0;
                        last_fill = pmem_address;
                    end
                    pmem_resp = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input logic ck, input logic [31:0] exp, output int cyc);
        sb.push_back('{ck, exp});
        mem_read = rd;
        mem_write = wr;
        mem_address = a;
        mem_wdata = wd;
        mem_byte_enable = be;
        cyc = 0;
        @(negedge clk);
        while (!mem_resp && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
        if (!mem_resp) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no resp for 0x%08h, expected resp", a);
            void'(sb.pop_back());
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        int cyc;
        int wb0;
        logic [255:0] l;
        checks = 0;
        errors = 0;
        lat = 1;
        wb_count = 0;
        last_wb = 32'd0;
        last_fill = 32'd0;
        l = mk_line(32'h1000_0000);
        l[63:32] = 32'hDEAD_BEEF;
        mem_model[32'h0000_1000] = l;
        mem_model[32'h0000_3000] = mk_line(32'h3000_0000);
        rst = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_address = 32'd0;
        mem_wdata = 32'd0;
        mem_byte_enable = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_resp", {31'd0, mem_resp}, 32'd0);
        chk("reset_pmem_rw", {30'd0, pmem_read, pmem_write}, 32'd0);
        chk("reset_pmem_addr", pmem_address, 32'd0);
        @(posedge clk);
        #1;

        access(1'b1, 1'b0, 32'h0000_1004, 32'd0, 4'h0, 1'b1, 32'hDEAD_BEEF, cyc);
        chk("cold_latency", 32'(cyc), 32'd2);
        chk("cold_fill_addr", last_fill, 32'h0000_1000);

        access(1'b1, 1'b0, 32'h0000_1008, 32'd0, 4'h0, 1'b1, 32'h1000_0002, cyc);
        chk("hit_latency", 32'(cyc), 32'd0);

        access(1'b0, 1'b1, 32'h0000_1004, 32'h00AB_0000, 4'b0100, 1'b0, 32'd0, cyc);
        chk("write_hit_latency", 32'(cyc), 32'd0);
        access(1'b1, 1'b0, 32'h0000_1004, 32'd0, 4'h0, 1'b1, 32'hDEAB_BEEF, cyc);

        lat = 6;
        wb0 = wb_count;
        access(1'b1, 1'b0, 32'h0000_3004, 32'd0, 4'h0, 1'b1, 32'h3000_0001, cyc);
        chk("dirty_miss_latency", 32'(cyc), 32'd13);
        chk("wb_addr", last_wb, 32'h0000_1000);
        chk("wb_count", 32'(wb_count), 32'(wb0 + 1));
        l = mem_model[32'h0000_1000];
        chk("wb_word1", l[63:32], 32'hDEAB_BEEF);
        chk("wb_word2", l[95:64], 32'h1000_0002);

        lat = 1000;
        mem_read = 1'b1;
        mem_address = 32'h0000_5004;
        repeat (3) @(negedge clk);
        chk("alloc_pmem_read", {31'd0, pmem_read}, 32'd1);
        chk("alloc_pmem_addr", pmem_address, 32'h0000_5000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_pmem_read", {31'd0, pmem_read}, 32'd0);
        @(posedge clk);
        #1;
        lat = 1;
        access(1'b1, 1'b0, 32'h0000_3004, 32'd0, 4'h0, 1'b1, 32'h3000_0001, cyc);
        chk("post_reset_miss_latency", 32'(cyc), 32'd2);

        access(1'b1, 1'b1, 32'h0000_3008, 32'h1234_5678, 4'b1111, 1'b0, 32'd0, cyc);
        chk("rdwr_latency", 32'(cyc), 32'd0);
        access(1'b1, 1'b0, 32'h0000_3008, 32'd0, 4'h0, 1'b1, 32'h1234_5678, cyc);
        access(1'b1, 1'b0, 32'h0000_1004, 32'd0, 4'h0, 1'b1, 32'hDEAB_BEEF, cyc);
        chk("dirty_miss_lat1", 32'(cyc), 32'd3);
        chk("wb2_addr", last_wb, 32'h0000_3000);
        l = mem_model[32'h0000_3000];
        chk("wb2_word2", l[95:64], 32'h1234_5678);

        access(1'b0, 1'b1, 32'h0000_1008, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'd0, cyc);
        access(1'b1, 1'b0, 32'h0000_1008, 32'd0, 4'h0, 1'b1, 32'h1000_0002, cyc);
        wb0 = wb_count;
        access(1'b1, 1'b0, 32'h0000_3004, 32'd0, 4'h0, 1'b1, 32'h3000_0001, cyc);
        chk("be0_dirty_wb", 32'(wb_count), 32'(wb0 + 1));
        chk("be0_latency", 32'(cyc), 32'd3);
        l = mem_model[32'h0000_1000];
        chk("be0_word2", l[95:64], 32'h1000_0002);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
